// File: rtl/reg_file.sv
// 32x32 integer register file: two combinational read ports, one write port, x0 reads zero.
// Optional same-cycle write-to-read forwarding when REGFILE_BYPASS_EN is defined.
module reg_file #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic [ADDR_WIDTH-1:0] raddr1,
    output logic [DATA_WIDTH-1:0] rdata1,
    input  logic [ADDR_WIDTH-1:0] raddr2,
    output logic [DATA_WIDTH-1:0] rdata2,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [DATA_WIDTH-1:0] wdata
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    // x0 has no storage; the array starts at x1
    logic [DATA_WIDTH-1:0] regs [1:DEPTH-1];
    logic [DATA_WIDTH-1:0] rd1;
    logic [DATA_WIDTH-1:0] rd2;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 1; i < DEPTH; i++) begin
                regs[i] <= '0;
            end
        end else if (we) begin
            for (int i = 1; i < DEPTH; i++) begin
                if (waddr == ADDR_WIDTH'(i)) begin
                    regs[i] <= wdata;
                end
            end
        end
    end

    always_comb begin
        rd1 = '0;
        rd2 = '0;
        for (int i = 1; i < DEPTH; i++) begin
            if (raddr1 == ADDR_WIDTH'(i)) begin
                rd1 = regs[i];
            end
            if (raddr2 == ADDR_WIDTH'(i)) begin
                rd2 = regs[i];
            end
        end
    end

`ifdef REGFILE_BYPASS_EN
    logic wr_live;
    logic fwd1;
    logic fwd2;

    // Forwarding is gated by reset so a held reset still reads zero
    assign wr_live = resetn && we && (waddr != '0);
    assign fwd1    = wr_live && (raddr1 == waddr);
    assign fwd2    = wr_live && (raddr2 == waddr);
    assign rdata1  = fwd1 ? wdata : rd1;
    assign rdata2  = fwd2 ? wdata : rd2;
`else
    assign rdata1 = rd1;
    assign rdata2 = rd2;
`endif

endmodule

// File: tb/tb_reg_file.sv
// Self-checking bench for reg_file: directed plan plus randomized traffic
// against an array model; define REGFILE_BYPASS_EN to check the forwarding build.
module tb_reg_file;

    logic        clk = 1'b0;
    logic        resetn;
    logic [4:0]  raddr1;
    logic [4:0]  raddr2;
    logic [4:0]  waddr;
    logic [31:0] rdata1;
    logic [31:0] rdata2;
    logic [31:0] wdata;
    logic        we;

    int vectors = 0;
    int miscompares = 0;

    logic [31:0] model [32];

    always #5 clk = ~clk;

    reg_file dut (
        .clk    (clk),
        .resetn (resetn),
        .raddr1 (raddr1),
        .rdata1 (rdata1),
        .raddr2 (raddr2),
        .rdata2 (rdata2),
        .we     (we),
        .waddr  (waddr),
        .wdata  (wdata)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ref_rd(input logic [4:0] a);
        if (!resetn || a == 5'd0) return 32'h0;
`ifdef REGFILE_BYPASS_EN
        if (we && waddr == a) return wdata;
`endif
        return model[a];
    endfunction

    task automatic clear_model();
        for (int i = 0; i < 32; i++) model[i] = 32'h0;
    endtask

    task automatic reads(input string tag);
        #1;
        check({tag, ".r1"}, rdata1, ref_rd(raddr1));
        check({tag, ".r2"}, rdata2, ref_rd(raddr2));
    endtask

    // One rising edge; the model commits exactly what a register file must
    task automatic tick();
        @(posedge clk);
        if (resetn && we && waddr != 5'd0) model[waddr] = wdata;
        @(negedge clk);
    endtask

    task automatic sweep_zero(input string tag);
        for (int a = 0; a < 32; a++) begin
            raddr1 = 5'(a);
            raddr2 = 5'(31 - a);
            #0.1;
            check({tag, ".r1"}, rdata1, 32'h0);
            check({tag, ".r2"}, rdata2, 32'h0);
        end
    endtask

    logic [31:0] pat [5];

    initial begin
        pat[0] = 32'h0000ffff;
        pat[1] = 32'h1111ffff;
        pat[2] = 32'h2222ffff;
        pat[3] = 32'h3333ffff;
        pat[4] = 32'h4444ffff;

        resetn = 1'b0;
        we     = 1'b0;
        waddr  = '0;
        wdata  = '0;
        raddr1 = '0;
        raddr2 = '0;
        clear_model();
        @(negedge clk);
        sweep_zero("reset");
        tick();
        resetn = 1'b1;
        tick();

        // x0 write is discarded
        we = 1'b1; waddr = 5'd0; wdata = 32'hdeadbeef;
        raddr1 = 5'd0; raddr2 = 5'd0;
        tick();
        we = 1'b0;
        #1;
        check("x0_r1", rdata1, 32'h0);
        check("x0_r2", rdata2, 32'h0);

        // write-enable gating
        we = 1'b0; waddr = 5'd1; wdata = 32'hffffffff;
        tick();
        raddr1 = 5'd1;
        #1;
        check("we_off", rdata1, 32'h0);
        we = 1'b1; wdata = 32'h1111ffff;
        tick();
        we = 1'b0; raddr2 = 5'd1; raddr1 = 5'd2;
        #1;
        check("we_on_x1", rdata2, 32'h1111ffff);
        check("we_on_x2", rdata1, 32'h0);

        // back-to-back writes x16..x20
        for (int i = 0; i < 5; i++) begin
            we = 1'b1;
            waddr = 5'(16 + i);
            wdata = pat[i];
            raddr1 = waddr;
            raddr2 = 5'(15 + i);
            reads("b2b");
            if (i > 0) check("b2b_prev", rdata2, pat[i-1]);
            tick();
        end
        we = 1'b0; raddr1 = 5'h15; raddr2 = 5'h14;
        #1;
        check("b2b_x21", rdata1, 32'h0);
        check("b2b_x20", rdata2, 32'h4444ffff);

        // readback sweep with idempotent rewrite of x20
        we = 1'b1; waddr = 5'h14; wdata = 32'h4444ffff;
        for (int i = 0; i < 5; i++) begin
            raddr1 = 5'(16 + i);
            raddr2 = 5'(15 + i);
            #1;
            check("sweep_r1", rdata1, pat[i]);
            check("sweep_r2", rdata2, (i == 0) ? 32'h0 : pat[i-1]);
            tick();
        end

        // same-cycle write/read hazard on x5
        we = 1'b1; waddr = 5'd5; wdata = 32'haaaa0000;
        tick();
        wdata = 32'h5555aaaa; raddr1 = 5'd5;
        #1;
`ifdef REGFILE_BYPASS_EN
        check("hazard_pre", rdata1, 32'h5555aaaa);
`else
        check("hazard_pre", rdata1, 32'haaaa0000);
`endif
        tick();
        we = 1'b0;
        #1;
        check("hazard_post", rdata1, 32'h5555aaaa);

        // dual port same address
        raddr1 = 5'h13; raddr2 = 5'h13;
        #1;
        check("dual_r1", rdata1, 32'h3333ffff);
        check("dual_r2", rdata2, 32'h3333ffff);

        // asynchronous reset mid-write, held across an edge
        we = 1'b1; waddr = 5'd7; wdata = 32'h12345678;
        #1;
        resetn = 1'b0;
        clear_model();
        sweep_zero("midrst");
        raddr1 = 5'd7; raddr2 = 5'd5;
        tick();
        reads("midrst_edge");
        we = 1'b0;
        #1;
        resetn = 1'b1;
        reads("midrst_rel");
        check("midrst_x7", rdata1, 32'h0);
        check("midrst_x5", rdata2, 32'h0);

        // randomized traffic
        for (int n = 0; n < 3000; n++) begin
            we    = 1'($urandom_range(0, 3) != 0);
            waddr = 5'($urandom);
            wdata = $urandom;
            raddr1 = ($urandom_range(0, 3) == 0) ? waddr : 5'($urandom);
            raddr2 = ($urandom_range(0, 3) == 0) ? waddr : 5'($urandom);
            reads("rand");
            if ($urandom_range(0, 199) == 0) begin
                resetn = 1'b0;
                clear_model();
                reads("rand_rst");
                #1;
                resetn = 1'b1;
                reads("rand_rel");
            end
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
